// File: rtl/cla_adder_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder.
package cla_adder_pkg;

  localparam int MAX_W = 64;

  // One pipeline stage: control bits plus the full-width data carried forward.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             cmsb;
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_rec_t;

  function automatic int seg_width(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  function automatic int num_groups(input int seg, input int group);
    return (seg + group - 1) / group;
  endfunction

endpackage

// File: rtl/cla_adder_segment.sv
// Combinational W-bit adder: full lookahead inside each GROUP, group carries ripple.
module cla_segment
  import cla_adder_pkg::*;
#(
  parameter int W     = 4,
  parameter int GROUP = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  localparam int NG = num_groups(W, GROUP);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each carry inside a group is the expanded sum-of-products from the group carry-in.
  always_comb begin
    logic gacc;
    logic pacc;
    gacc = 1'b0;
    pacc = 1'b0;
    c    = '0;
    c[0] = cin_i;
    for (int gi = 0; gi < NG; gi++) begin
      for (int j = gi * GROUP; j < (gi + 1) * GROUP; j++) begin
        if (j < W) begin
          gacc = g[j];
          pacc = p[j];
          for (int m = j - 1; m >= gi * GROUP; m--) begin
            gacc = gacc | (pacc & g[m]);
            pacc = pacc & p[m];
          end
          c[j+1] = gacc | (pacc & c[gi*GROUP]);
        end
      end
    end
  end

  assign sum_o  = p ^ c[W-1:0];
  assign cout_o = c[W];
  assign cmsb_o = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor with valid/ready flow control and overflow flag.
// Optional carry-in port enabled by defining CLA_ADDER_CIN_EN.
module pipelined_cla_adder
  import cla_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_sub,
`ifdef CLA_ADDER_CIN_EN
  input  logic             i_cin,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  stage_rec_t        stage_q [STAGES];
  stage_rec_t        stage_d [STAGES];
  stage_rec_t        src0;
  logic              c0;
  logic              en;
  logic [STAGES-1:0] unused_par;

  assign en      = !stage_q[STAGES-1].valid | i_ready;
  assign o_ready = en;

`ifdef CLA_ADDER_CIN_EN
  assign c0 = i_sub | i_cin;
`else
  assign c0 = i_sub;
`endif

  always_comb begin
    src0              = '0;
    src0.valid        = i_valid;
    src0.carry        = c0;
    src0.a[WIDTH-1:0] = i_add1;
    src0.b[WIDTH-1:0] = i_add2 ^ {WIDTH{i_sub}};
  end

  // Stage k adds bits [HI-1:LO]; trailing stages with no bits just pass through.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
    localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
    localparam int SW = HI - LO;

    stage_rec_t src;
    stage_rec_t nxt;

    if (k == 0) begin : g_first
      assign src = src0;
    end else begin : g_next
      assign src = stage_q[k-1];
    end

    if (SW > 0) begin : g_seg
      logic [SW-1:0] sum;
      logic          cout;
      logic          cmsb;

      cla_segment #(
        .W     (SW),
        .GROUP (GROUP)
      ) u_seg (
        .a_i    (src.a[HI-1:LO]),
        .b_i    (src.b[HI-1:LO]),
        .cin_i  (src.carry),
        .sum_o  (sum),
        .cout_o (cout),
        .cmsb_o (cmsb)
      );

      always_comb begin
        nxt             = src;
        nxt.res[HI-1:LO] = sum;
        nxt.carry       = cout;
        nxt.cmsb        = (HI == WIDTH) ? cmsb : src.cmsb;
      end
    end else begin : g_pass
      assign nxt = src;
    end

    assign stage_d[k]    = nxt;
    assign unused_par[k] = ^stage_q[k];
  end

  // Single global advance: all stages move together or all hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k].valid <= 1'b0;
      end
      stage_q[STAGES-1].res   <= '0;
      stage_q[STAGES-1].carry <= 1'b0;
      stage_q[STAGES-1].cmsb  <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign o_valid  = stage_q[STAGES-1].valid;
  assign o_result = stage_q[STAGES-1].res[WIDTH-1:0];
  assign o_cout   = stage_q[STAGES-1].carry;
  assign o_ovf    = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].cmsb;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: main DUT (16b, 2 stages, group 4) plus alternate depth/group builds.
module tb_pipelined_cla_adder;

  localparam int W    = 16;
  localparam int LAT  = 2;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vin = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         rdy = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;

  logic         ordy;
  logic         ovld;
  logic [W-1:0] res;
  logic         cout;
  logic         ovf;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen_stall = 1'b0;
  bit   rnd_done = 1'b0;
  exp_t expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_adder #(.WIDTH(W), .STAGES(LAT), .GROUP(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (vin),
    .o_ready  (ordy),
    .i_add1   (a),
    .i_add2   (b),
    .i_sub    (sub),
`ifdef CLA_ADDER_CIN_EN
    .i_cin    (cin),
`endif
    .o_valid  (ovld),
    .i_ready  (rdy),
    .o_result (res),
    .o_cout   (cout),
    .o_ovf    (ovf)
  );

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    exp_t   e;
    longint ux, uy, sx, sy, u, sv;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      u  = ux - uy + (longint'(1) << W);
      sv = sx - sy;
    end else begin
      u  = ux + uy + longint'(c);
      sv = sx + sy + longint'(c);
    end
    e.r  = u[W-1:0];
    e.co = u[W];
    e.ov = (sv > MAXS) || (sv < MINS);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input logic c, input exp_t e);
    int k;
    k   = 0;
    a   = x;
    b   = y;
    sub = s;
    cin = c;
    vin = 1'b1;
    forever begin
      @(negedge clk);
      if (ordy) begin
        expq.push_back(e);
        acc_cyc = cyc;
        break;
      end
      k++;
      if (k > 200) begin
        chk("send_timeout", 64'(0), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ovld) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    chk(name, 64'(lat), 64'(LAT));
  endtask

  task automatic drain();
    int k;
    k   = 0;
    rdy = 1'b1;
    while (expq.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  // Main output monitor: pop on every delivered beat.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ovld && rdy) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", 64'({res, cout, ovf}), 64'(0));
      end else begin
        e = expq.pop_front();
        chk("beat", 64'({res, cout, ovf}), 64'(e));
      end
    end
  end

  // Flow-control rules: o_ready tracks back-pressure, held outputs stay put.
  logic             prev_hold = 1'b0;
  logic [W+1:0]     prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("o_ready_rule", 64'(ordy), 64'(!ovld | rdy));
      if (prev_hold) chk("hold_stable", 64'({ovld, res, cout, ovf}), 64'({1'b1, prev_out}));
      if (ovld && !rdy && !ordy) seen_stall = 1'b1;
      prev_hold = ovld && !rdy;
      prev_out  = {res, cout, ovf};
    end
  end

  // Alternate builds: same operands, never back-pressured, own scoreboard each.
  for (genvar gi = 0; gi < 3; gi++) begin : g_alt
    localparam int ST = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    localparam int GR = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;

    logic         ordy_x;
    logic         ovld_x;
    logic [W-1:0] res_x;
    logic         co_x;
    logic         ov_x;
    exp_t         q[$];

    pipelined_cla_adder #(.WIDTH(W), .STAGES(ST), .GROUP(GR)) u_alt (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (vin),
      .o_ready  (ordy_x),
      .i_add1   (a),
      .i_add2   (b),
      .i_sub    (sub),
`ifdef CLA_ADDER_CIN_EN
      .i_cin    (cin),
`endif
      .o_valid  (ovld_x),
      .i_ready  (1'b1),
      .o_result (res_x),
      .o_cout   (co_x),
      .o_ovf    (ov_x)
    );

    always @(posedge clk) begin
      if (rst) q.delete();
      else if (vin) q.push_back(model(a, b, sub, cin));
    end

    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        chk($sformatf("alt%0d_ready", gi), 64'(ordy_x), 64'(1));
        if (ovld_x) begin
          if (q.size() == 0) begin
            chk($sformatf("alt%0d_unexpected", gi), 64'({res_x, co_x, ov_x}), 64'(0));
          end else begin
            e = q.pop_front();
            chk($sformatf("alt%0d_beat", gi), 64'({res_x, co_x, ov_x}), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y;
    logic         s, c;
    logic [W-1:0] corners [4];
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(ovld), 64'(0));
    chk("rst_ready", 64'(ordy), 64'(1));
    chk("rst_outputs", 64'({res, cout, ovf}), 64'(0));
    @(posedge clk);
    #1;

    // Directed corners with hand-computed results.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{r: 16'h0000, co: 1'b1, ov: 1'b0});
    wait_valid("latency_first");
    drain();
    send(16'h0005, 16'h0007, 1'b1, 1'b0, '{r: 16'hFFFE, co: 1'b0, ov: 1'b0});
    send(16'h8000, 16'h0001, 1'b1, 1'b0, '{r: 16'h7FFF, co: 1'b1, ov: 1'b1});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{r: 16'h8000, co: 1'b0, ov: 1'b1});
`ifdef CLA_ADDER_CIN_EN
    send(16'h00FF, 16'h0000, 1'b0, 1'b1, '{r: 16'h0100, co: 1'b0, ov: 1'b0});
    send(16'h0003, 16'h0001, 1'b1, 1'b1, '{r: 16'h0002, co: 1'b1, ov: 1'b0});
`endif
    drain();

    // Six back-to-back beats, consumer stalls for cycles 3-5.
    seen_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          x = W'($urandom);
          y = W'($urandom);
          s = 1'($urandom_range(0, 1));
          send(x, y, s, 1'b0, model(x, y, s, 1'b0));
        end
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rdy = 1'b1;
      end
    join
    drain();
    chk("stall_seen", 64'(seen_stall), 64'(1));

    // Reset with two beats in flight and a beat offered during reset.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h0444, 1'b1, 1'b0, model(16'h3333, 16'h0444, 1'b1, 1'b0));
    rst = 1'b1;
    expq.delete();
    a   = 16'hABCD;
    b   = 16'h1234;
    vin = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vin = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(ovld), 64'(0));
    chk("flush_ready", 64'(ordy), 64'(1));
    @(posedge clk);
    #1;
    send(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, '{r: 16'h0000, co: 1'b1, ov: 1'b0});
    wait_valid("latency_after_rst");
    drain();

    // Random operands, random gaps, random back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            vin = 1'b0;
            @(posedge clk);
            #1;
          end
          x = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
          y = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
          s = 1'($urandom_range(0, 1));
`ifdef CLA_ADDER_CIN_EN
          c = 1'($urandom_range(0, 1));
`else
          c = 1'b0;
`endif
          send(x, y, s, c, model(x, y, s, c));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rdy = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        rdy = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
